// File: rtl/wb_pkg.sv
// Shared writeback types for the register-file write port.
// Entry bundle carried through the LSU result FIFO.
package wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries for the LSU result path.
// Caller guarantees no push when full and no pop when empty.
import wb_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  wb_entry_t     i_din,
    input  logic          i_pop,
    output wb_entry_t     o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    wb_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wptr] <= i_din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + AW'(1);
            if (i_pop)
                r_rptr <= r_rptr + AW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and buffered LSU results onto the register-file write port.
// ALU wins unless the LSU FIFO has starved for STARVE_LIMIT cycles.
import wb_pkg::*;

module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int WW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_wdata,
    output logic            o_alu_stall,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_rf_en,
    output logic [4:0]      o_rf_rd,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic [CW-1:0]   o_fifo_count
);

    wb_entry_t       w_din;
    wb_entry_t       w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_alu_gnt;
    logic [WW-1:0]   w_wait_nxt;

    logic [WW-1:0]   r_wait;
    logic            r_rf_en;
    logic [4:0]      r_rf_rd;
    logic [XLEN-1:0] r_rf_wdata;

    assign w_din       = '{rd: i_lsu_rd, wdata: i_lsu_wdata};
    assign o_lsu_ready = !rst && !w_full;
    assign w_push      = i_lsu_valid && o_lsu_ready;
    assign o_alu_stall = (r_wait == WW'(STARVE_LIMIT));
    assign w_alu_gnt   = i_alu_valid && !o_alu_stall;
    assign w_pop       = !w_alu_gnt && !w_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_wait_nxt = '0;
        if (!w_pop && !w_empty) begin
            if (r_wait == WW'(STARVE_LIMIT))
                w_wait_nxt = r_wait;
            else
                w_wait_nxt = r_wait + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait     <= '0;
            r_rf_en    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_wait <= w_wait_nxt;
            unique case (1'b1)
                w_alu_gnt: begin
                    r_rf_en    <= (i_alu_rd != '0);
                    r_rf_rd    <= i_alu_rd;
                    r_rf_wdata <= i_alu_wdata;
                end
                w_pop: begin
                    r_rf_en    <= (w_head.rd != '0);
                    r_rf_rd    <= w_head.rd;
                    r_rf_wdata <= w_head.wdata;
                end
                default: r_rf_en <= 1'b0;
            endcase
        end
    end

    assign o_rf_en      = r_rf_en;
    assign o_rf_rd      = r_rf_rd;
    assign o_rf_wdata   = r_rf_wdata;
    assign o_fifo_count = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based model.
// The model tracks FIFO contents, starvation age and the expected write port.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    logic [36:0] q[$];
    int          m_wait;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    int          n_wr;
    int          n_stall;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_alu_valid  (alu_valid),
        .i_alu_rd     (alu_rd),
        .i_alu_wdata  (alu_wdata),
        .o_alu_stall  (alu_stall),
        .i_lsu_valid  (lsu_valid),
        .o_lsu_ready  (lsu_ready),
        .i_lsu_rd     (lsu_rd),
        .i_lsu_wdata  (lsu_wdata),
        .o_rf_en      (rf_en),
        .o_rf_rd      (rf_rd),
        .o_rf_wdata   (rf_wdata),
        .o_fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs, step model,
    // then check the registered write port after the edge.
    task automatic cyc(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] awd, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] lwd);
        logic stall, ready, agnt, pop;
        logic [36:0] e;
        int sz;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_wdata = awd;
        lsu_valid = lv; lsu_rd = lrd; lsu_wdata = lwd;
        #1;
        if (r) begin
            chk("ready_in_rst", 32'(lsu_ready), 32'd0);
            q.delete();
            m_wait = 0; m_en = 1'b0; m_rd = '0; m_wd = '0;
        end else begin
            sz    = q.size();
            stall = (m_wait == LIM);
            ready = (sz < DEPTH);
            chk("stall", 32'(alu_stall), 32'(stall));
            chk("ready", 32'(lsu_ready), 32'(ready));
            chk("count", 32'(fifo_count), 32'(sz));
            if (stall) n_stall++;
            agnt = av && !stall;
            pop  = !agnt && sz != 0;
            if (agnt) begin
                m_en = (ard != 0); m_rd = ard; m_wd = awd;
            end else if (pop) begin
                e = q.pop_front();
                m_rd = e[36:32]; m_wd = e[31:0]; m_en = (m_rd != 0);
            end else begin
                m_en = 1'b0;
            end
            if (pop || sz == 0) m_wait = 0;
            else if (m_wait < LIM) m_wait++;
            if (lv && ready) q.push_back({lrd, lwd});
        end
        @(posedge clk);
        #1;
        chk("rf_en", 32'(rf_en), 32'(m_en));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_wdata", rf_wdata, m_wd);
        if (rf_en) n_wr++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int base, first;
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
        n_wr = 0; n_stall = 0;
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_stall", 32'(alu_stall), 32'd0);

        // ALU only
        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("t1_en", 32'(rf_en), 32'd1);
        chk("t1_data", rf_wdata, 32'hDEADBEEF);
        idle(1);
        chk("t1_en_off", 32'(rf_en), 32'd0);

        // x0 filtering on both paths
        base = n_wr;
        cyc(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        idle(3);
        chk("t2_nowr", 32'(n_wr - base), 32'd0);
        chk("t2_cnt", 32'(fifo_count), 32'd0);

        // LSU back-to-back, writes at +2 and +3
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5A5A5);
        chk("t3_e1", 32'(rf_en), 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h5A5A5A5A);
        chk("t3_w1", rf_wdata, 32'hA5A5A5A5);
        idle(1);
        chk("t3_w2", rf_wdata, 32'h5A5A5A5A);
        chk("t3_rd2", 32'(rf_rd), 32'd8);
        idle(2);

        // Starvation: ALU held, two LSU pushes
        n_stall = 0; first = -1;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b1, 5'(1 + k % 30), 32'(k), k < 2,
                5'(20 + k), 32'hC000_0000 + 32'(k));
            if (k == 2) begin
                chk("t4_full", 32'(fifo_count), 32'd2);
                chk("t4_nrdy", 32'(lsu_ready), 32'd0);
            end
            if (first < 0 && n_stall != 0) first = k;
        end
        chk("t4_first", 32'(first), 32'd5);
        chk("t4_stalls", 32'(n_stall), 32'd2);
        chk("t4_empty", 32'(fifo_count), 32'd0);
        alu_valid = 1'b0;

        // Wrap-around with idle gaps
        base = n_wr;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + k), 32'h1000 + 32'(k));
            if (k % 3 == 1) idle(1);
        end
        idle(4);
        chk("t5_writes", 32'(n_wr - base), 32'd10);

        // Reset with FIFO full and write pending
        cyc(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
        cyc(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd6, 32'd3);
        chk("t6_cnt2", 32'(fifo_count), 32'd2);
        chk("t6_pend", 32'(rf_en), 32'd1);
        cyc(1'b1, 1'b1, 5'd3, 32'd1, 1'b1, 5'd9, 32'd4);
        chk("t6_en0", 32'(rf_en), 32'd0);
        chk("t6_cnt0", 32'(fifo_count), 32'd0);
        chk("t6_stall0", 32'(alu_stall), 32'd0);
        base = n_wr;
        idle(4);
        chk("t6_nostale", 32'(n_wr - base), 32'd0);

        // Random traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(99) == 0, 1'($urandom), 5'($urandom),
                $urandom, 1'($urandom), 5'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback-side producer for the 32-entry register file. It merges results from the single-cycle ALU path and the long-latency LSU/mul-div path into the register file write port (rf_en, rf_rd, rf_wdata).
- LSU results are buffered in a small FIFO.
- ALU has priority, with starvation protection for the LSU path.
- Writes to x0 are filtered here; the register file itself does not protect x0.

Parameters:
XLEN, 32, data width of results and rf_wdata
DEPTH, 2, LSU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go unserved before the ALU is stalled

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result present this cycle; no backpressure except alu_stall
alu_rd  in  5  ALU destination register
alu_wdata  in  XLEN  ALU result
alu_stall  out  1  pipeline must hold its ALU result this cycle; arbiter ignores alu_valid while high
lsu_valid  in  1  LSU result offered
lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
lsu_rd  in  5  LSU destination register
lsu_wdata  in  XLEN  LSU result
rf_en  out  1  register file write enable (registered)
rf_rd  out  5  register file write address (registered)
rf_wdata  out  XLEN  register file write data (registered)
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Reset and clocking:
- All state updates on posedge clk.
- rst overrides everything: rf_en=0, rf_rd=0, rf_wdata=0, FIFO emptied (count=0, pointers 0), wait_cnt=0, alu_stall=0.
- lsu_ready=0 while rst is high.
- Reset mid-operation drops all buffered LSU results and any pending write; no write is issued in the cycle after reset.

LSU FIFO:
- lsu_ready = !rst && (count < DEPTH). It depends only on occupancy, not on the pop decision: when full, ready stays 0 even in a pop cycle.
- Push: on lsu_valid && lsu_ready, {lsu_rd, lsu_wdata} is written at the tail.
- There is no bypass; every LSU result goes through the FIFO.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo DEPTH.

Grant, evaluated each cycle:
1. alu_valid && !alu_stall → grant ALU.
2. Otherwise, if count != 0 → pop the FIFO head (its pre-push contents) and grant it.
3. Otherwise → no grant.

Output register:
- On a grant, the next cycle has rf_rd and rf_wdata = granted entry, and rf_en = (granted rd != 0).
- An entry with rd == 0 is consumed and popped but produces rf_en=0. rf_rd and rf_wdata still load, so they are don't-care when rf_en=0.
- With no grant, the next cycle has rf_en=0 and rf_rd/rf_wdata hold their previous values.

Latency:
- ALU result: rf_en asserted 1 cycle after alu_valid is sampled.
- LSU result: minimum 2 cycles after the handshake (push edge, then pop).

Starvation counter:
- wait_cnt is a register in 0..STARVE_LIMIT, saturating.
- Next value: 0 if pop or count==0 this cycle, else wait_cnt+1.
- alu_stall = (wait_cnt == STARVE_LIMIT), decoded from the register with no combinational path from inputs.
- When alu_stall=1, the FIFO head is granted in that cycle and wait_cnt clears, so alu_stall lasts exactly 1 cycle per starvation event.

Ordering and hazards:
- Results within each source are written in arrival order. There is no ordering guarantee between sources.
- The hazard/scoreboard logic must not issue two in-flight writes to the same rd from different sources.

Decomposition:
- Package wb_pkg: localparam REG_AW=5, NUM_REGS=32; typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] wdata;} wb_entry_t. XLEN is fixed at 32 in the package and the parameter must match.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with DEPTH, push/pop/count/full/empty, same reset.
- Arbitration, starvation counter and output register live in wb_arbiter.

Test Plan:
1. ALU only: alu_valid with rd=5, wdata=0xDEADBEEF → next cycle rf_en=1, rf_rd=5, rf_wdata=0xDEADBEEF; the cycle after, rf_en=0.
2. x0 filter: alu rd=0, wdata=0x1234, then LSU rd=0 → rf_en never asserts; FIFO drains to count=0.
3. LSU only: push rd=7/0xA5A5A5A5 then rd=8/0x5A5A5A5A back-to-back → writes appear at cycles +2 and +3 in order; lsu_ready stays 1 with DEPTH=2.
4. Full/backpressure: hold alu_valid continuously and push 2 LSU results → count=2 and lsu_ready=0. Exactly 4 cycles after the first push wait_cnt==4, so alu_stall=1 for 1 cycle and the LSU head is written. Repeat until empty.
5. Wrap-around: 10 LSU results with interleaved idle cycles → all 10 written in order with correct data; pointers wrap without loss.
6. Reset mid-op: FIFO count=2 and rf_en=1 pending, assert rst for 1 cycle → rf_en=0, count=0, alu_stall=0, lsu_ready=0 during rst; no stale write appears after release.
